// File: rtl/sdspi_arbiter.sv
// Round-robin arbiter sharing one sdspihost between two read requesters.
// Owns host reset/init and recovers a hung host through a busy watchdog.
module sdspi_arbiter #(
    parameter int TIMEOUT_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        r_block0,
    input  logic        r_block1,
    input  logic        r_multi0,
    input  logic        r_multi1,
    input  logic        r_byte0,
    input  logic        r_byte1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy0,
    output logic        busy1,
    output logic [7:0]  data_o,
    output logic        ready,
    output logic        timeout_err,
    output logic        host_rst,
    output logic        host_r_block,
    output logic        host_r_multi_block,
    output logic        host_r_byte,
    output logic [31:0] host_block_addr,
    input  logic        host_busy,
    input  logic [7:0]  host_data_out
);

    typedef enum logic [2:0] {
        INIT_RST, INIT_BUSY, INIT_IDLE, IDLE, GNT0, GNT1, RELEASE
    } state_t;

    state_t               state, state_nxt;
    logic                 last;
    logic [TIMEOUT_W-1:0] wd_cnt;
    logic                 wd_watched, wd_fire;

    // INIT_BUSY is excluded: the host may legitimately take a long time to come up.
    assign wd_watched = (state == INIT_IDLE) || (state == GNT0) ||
                        (state == GNT1) || (state == RELEASE);
    assign wd_fire    = wd_watched && (wd_cnt == {TIMEOUT_W{1'b1}});

    always_comb begin
        state_nxt = state;
        case (state)
            INIT_RST:  state_nxt = INIT_BUSY;
            INIT_BUSY: if (host_busy)  state_nxt = INIT_IDLE;
            INIT_IDLE: if (!host_busy) state_nxt = IDLE;
            IDLE: begin
                if (req0 && req1) state_nxt = last ? GNT0 : GNT1;
                else if (req0)    state_nxt = GNT0;
                else if (req1)    state_nxt = GNT1;
            end
            GNT0:    if (!req0)      state_nxt = RELEASE;
            GNT1:    if (!req1)      state_nxt = RELEASE;
            RELEASE: if (!host_busy) state_nxt = IDLE;
            default: state_nxt = INIT_RST;
        endcase
        if (wd_fire) state_nxt = INIT_RST;
    end

    // Outputs are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT_RST;
            last        <= 1'b1;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
            host_rst    <= 1'b1;
            ready       <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
        end else begin
            state    <= state_nxt;
            host_rst <= (state_nxt == INIT_RST);
            ready    <= (state_nxt == IDLE) || (state_nxt == GNT0) ||
                        (state_nxt == GNT1) || (state_nxt == RELEASE);
            gnt0     <= (state_nxt == GNT0);
            gnt1     <= (state_nxt == GNT1);
            if (state == IDLE && state_nxt == GNT0) last <= 1'b0;
            if (state == IDLE && state_nxt == GNT1) last <= 1'b1;
            if (wd_fire) timeout_err <= 1'b1;
            wd_cnt <= (!wd_fire && wd_watched && host_busy) ? wd_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        host_r_block       = 1'b0;
        host_r_multi_block = 1'b0;
        host_r_byte        = 1'b0;
        host_block_addr    = '0;
        if (gnt0) begin
            host_r_block       = r_block0;
            host_r_multi_block = r_multi0;
            host_r_byte        = r_byte0;
            host_block_addr    = addr0;
        end else if (gnt1) begin
            host_r_block       = r_block1;
            host_r_multi_block = r_multi1;
            host_r_byte        = r_byte1;
            host_block_addr    = addr1;
        end
    end

    // Ungranted requesters see a permanently busy host and stall.
    assign busy0  = gnt0 ? host_busy : 1'b1;
    assign busy1  = gnt1 ? host_busy : 1'b1;
    assign data_o = host_data_out;

endmodule

// File: tb/tb_sdspi_arbiter.sv
// Scoreboard bench for sdspi_arbiter: stimulus queues expected events, a
// negedge monitor detects events on the DUT and checks them against the queue.
module tb_sdspi_arbiter;

    logic        clk = 1'b0;
    logic        rst, req0, req1, r_block0, r_block1, r_multi0, r_multi1, r_byte0, r_byte1;
    logic [31:0] addr0, addr1;
    logic        gnt0, gnt1, busy0, busy1, ready, timeout_err;
    logic [7:0]  data_o;
    logic        host_rst, host_r_block, host_r_multi_block, host_r_byte;
    logic [31:0] host_block_addr;
    logic        host_busy;
    logic [7:0]  host_data_out;

    logic tb_busy = 1'b0;
    int   mcnt    = 100;
    int   cyc     = 0;
    int   errors  = 0;
    int   checks  = 0;

    localparam logic [7:0] K_RSTV = 8'd1, K_HRST = 8'd2, K_RDY = 8'd3, K_TERR = 8'd4,
                           K_TFALL = 8'd5, K_G0 = 8'd6, K_G1 = 8'd7;

    typedef struct {
        string       name;
        logic [7:0]  kind;
        logic [31:0] data;
        int          cyc;
        bit          chk_cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    sdspi_arbiter #(.TIMEOUT_W(4)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .r_block0(r_block0), .r_block1(r_block1), .r_multi0(r_multi0), .r_multi1(r_multi1),
        .r_byte0(r_byte0), .r_byte1(r_byte1), .addr0(addr0), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .busy0(busy0), .busy1(busy1), .data_o(data_o),
        .ready(ready), .timeout_err(timeout_err), .host_rst(host_rst),
        .host_r_block(host_r_block), .host_r_multi_block(host_r_multi_block),
        .host_r_byte(host_r_byte), .host_block_addr(host_block_addr),
        .host_busy(host_busy), .host_data_out(host_data_out)
    );

    // Host model: busy rises 3 cycles after host_rst and stays up 10 cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (host_rst === 1'b1) mcnt <= 0;
        else if (mcnt < 20)    mcnt <= mcnt + 1;
    end
    assign host_busy     = tb_busy | (mcnt >= 3 && mcnt <= 12);
    assign host_data_out = 8'(cyc * 7);

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input string n, input logic [7:0] k, input logic [31:0] d,
                             input int c, input bit cc);
        exp_t e;
        e.name = n; e.kind = k; e.data = d; e.cyc = c; e.chk_cyc = cc;
        sb.push_back(e);
    endtask

    task automatic emit(input logic [7:0] k, input logic [31:0] d);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d data=%h cyc=%0d, required no event", k, d, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind !== k || e.data !== d || (e.chk_cyc && e.cyc != cyc)) begin
                errors++;
                $display("FAIL %s: got kind=%0d data=%h cyc=%0d, required kind=%0d data=%h cyc=%0d",
                         e.name, k, d, cyc, e.kind, e.data, e.chk_cyc ? e.cyc : -1);
            end
        end
    endtask

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %h, required %h", n, cyc, got, exp);
        end
    endtask

    // Monitor
    logic rst_at_edge = 1'b0;
    logic p_hb, p_ready, p_terr, p_g0, p_g1;
    int   hrst_w = 0;
    int   busy_fall = 0;
    always @(posedge clk) rst_at_edge <= rst;

    always @(negedge clk) begin
        logic [34:0] hexp;
        if (cyc >= 1) begin
            hexp = gnt0 ? {r_block0, r_multi0, r_byte0, addr0} :
                   gnt1 ? {r_block1, r_multi1, r_byte1, addr1} : 35'd0;
            chk("onehot", {63'd0, gnt0 & gnt1}, 64'd0);
            chk("busy_i", {62'd0, busy0, busy1},
                {62'd0, (gnt0 ? host_busy : 1'b1), (gnt1 ? host_busy : 1'b1)});
            chk("host_strobes", {29'd0, host_r_block, host_r_multi_block, host_r_byte, host_block_addr},
                {29'd0, hexp});
            chk("data_o", {56'd0, data_o}, {56'd0, host_data_out});

            if (rst_at_edge)
                emit(K_RSTV, {21'd0, gnt0, gnt1, ready, timeout_err, busy0, busy1, host_rst,
                              host_r_block, host_r_multi_block, host_r_byte, (host_block_addr != 0)});
            if (host_rst === 1'b1) hrst_w++;
            else if (hrst_w > 0) begin
                emit(K_HRST, 32'(hrst_w));
                hrst_w = 0;
            end
            if (p_hb === 1'b1 && host_busy === 1'b0) busy_fall = cyc;
            if (p_ready === 1'b0 && ready === 1'b1) emit(K_RDY, 32'(cyc - busy_fall));
            if (p_terr === 1'b0 && timeout_err === 1'b1) emit(K_TERR, 32'd0);
            if (p_terr === 1'b1 && timeout_err === 1'b0) emit(K_TFALL, 32'd0);
            if (p_g0 === 1'b0 && gnt0 === 1'b1)
                emit(K_G0, {13'd0, host_r_block, host_r_multi_block, host_r_byte, host_block_addr[15:0]});
            if (p_g1 === 1'b0 && gnt1 === 1'b1)
                emit(K_G1, {13'd0, host_r_block, host_r_multi_block, host_r_byte, host_block_addr[15:0]});
        end
        p_hb = host_busy; p_ready = ready; p_terr = timeout_err; p_g0 = gnt0; p_g1 = gnt1;
    end

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: got ready=%b after %0d cycles, required 1", ready, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at cyc %0d, required finish", cyc);
        $fatal(1);
    end

    initial begin
        int t, gstart, owner;
        rst = 1'b1; req0 = 0; req1 = 0; r_block0 = 0; r_block1 = 0; r_multi0 = 0; r_multi1 = 0;
        r_byte0 = 0; r_byte1 = 0; addr0 = '0; addr1 = '0;

        // 1. Init
        expect_ev("reset_state", K_RSTV, 32'h070, 1, 1);
        expect_ev("init_hrst_width", K_HRST, 32'd1, 2, 1);
        expect_ev("init_ready_after_busy", K_RDY, 32'd1, 0, 0);
        step(1);
        rst = 1'b0;
        wait_ready();

        // 2. Single requester; port 1 strobes must be ignored
        req0 = 1; addr0 = 32'h5; r_block0 = 1;
        r_block1 = 1; r_multi1 = 1; addr1 = 32'hAA;
        expect_ev("single_g0", K_G0, 32'h40005, cyc + 1, 1);
        step(5);
        req0 = 0;
        step(4);

        // 3. Simultaneous requests alternate (port 0 was last, so 1 first)
        r_block0 = 0; r_multi0 = 1; addr0 = 32'h10;
        r_block1 = 0; r_multi1 = 0; r_byte1 = 1; addr1 = 32'h20;
        req0 = 1; req1 = 1;
        expect_ev("rr_g1_first", K_G1, 32'h10020, cyc + 1, 1);
        gstart = cyc + 1;
        owner = 1;
        for (int k = 0; k < 3; k++) begin
            step(gstart + 20 - cyc);
            t = cyc;
            if (owner == 1) req1 = 0; else req0 = 0;
            if (owner == 1) expect_ev("rr_g0", K_G0, 32'h20010, t + 3, 1);
            else            expect_ev("rr_g1", K_G1, 32'h10020, t + 3, 1);
            step(1);
            if (owner == 1) req1 = 1; else req0 = 1;
            gstart = t + 3;
            owner = 1 - owner;
        end
        step(gstart + 5 - cyc);
        req0 = 0; req1 = 0;
        step(4);

        // 4. Release while host busy for 6 more cycles
        req0 = 1;
        expect_ev("rel_g0", K_G0, 32'h20010, cyc + 1, 1);
        step(3);
        t = cyc;
        tb_busy = 1; req0 = 0;
        expect_ev("rel_g1_after_busy", K_G1, 32'h10020, t + 9, 1);
        step(1);
        req1 = 1;
        step(6);
        tb_busy = 0;
        step(5);
        req1 = 0;
        step(4);

        // 5. Watchdog with busy stuck in GNT0
        req0 = 1; addr0 = 32'h44; r_block0 = 1; r_multi0 = 0;
        t = cyc;
        expect_ev("wd_g0", K_G0, 32'h40044, t + 1, 1);
        expect_ev("wd_timeout", K_TERR, 32'd0, t + 17, 1);
        expect_ev("wd_hrst_width", K_HRST, 32'd1, t + 18, 1);
        expect_ev("wd_ready_again", K_RDY, 32'd1, 0, 0);
        step(1);
        tb_busy = 1;
        step(16);
        tb_busy = 0; req0 = 0;
        wait_ready();
        step(3);

        // 6. Reset mid-grant on port 1, then both request
        req1 = 1;
        expect_ev("rstg_g1", K_G1, 32'h10020, cyc + 1, 1);
        step(3);
        t = cyc;
        rst = 1;
        req0 = 1; addr0 = 32'h33; r_block0 = 0; r_byte0 = 1;
        expect_ev("midgrant_reset_state", K_RSTV, 32'h070, t + 1, 1);
        expect_ev("midgrant_terr_clear", K_TFALL, 32'd0, t + 1, 1);
        expect_ev("midgrant_hrst_width", K_HRST, 32'd1, t + 2, 1);
        expect_ev("midgrant_ready", K_RDY, 32'd1, 0, 0);
        expect_ev("post_reset_g0_first", K_G0, 32'h10033, 0, 0);
        step(1);
        rst = 0;
        wait_ready();
        step(3);
        req0 = 0; req1 = 0;
        step(5);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending (next %s), required 0", sb.size(), sb[0].name);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdspi_arbiter.md
# sdspi_arbiter

Two-port arbiter that shares one `sdspihost` instance between two read requesters, for example the block-read benchmark FSM and a debug/readback engine. It owns the host's reset and initialisation sequence. It grants the host to one requester at a time using round-robin, and routes that requester's command strobes and block address to the host. A busy watchdog recovers the host if it hangs.

## Interface
Parameters:
- `TIMEOUT_W`, default 24: watchdog counter width. Timeout fires at 2^TIMEOUT_W−1 consecutive busy cycles.

Ports:
- `clk` in 1: single clock, shared with `sdspihost`.
- `rst` in 1: synchronous, active-high reset.
- `req0`, `req1` in 1: session request. Held high for the entire session.
- `r_block0`, `r_block1` in 1: single-block read strobe, level-held as on `sdspihost`.
- `r_multi0`, `r_multi1` in 1: CMD18 multi-block read strobe.
- `r_byte0`, `r_byte1` in 1: byte fetch strobe.
- `addr0`, `addr1` in 32: block address.
- `gnt0`, `gnt1` out 1: grant, registered, one-hot or zero.
- `busy0`, `busy1` out 1: `host_busy` while granted, otherwise 1.
- `data_o` out 8: `host_data_out` passed through to both requesters.
- `ready` out 1: host initialised and arbiter accepting requests.
- `timeout_err` out 1: sticky; set by the watchdog, cleared only by `rst`.
- `host_rst`, `host_r_block`, `host_r_multi_block`, `host_r_byte` out 1: drive the `sdspihost` inputs.
- `host_block_addr` out 32: drives `sdspihost` `block_addr`.
- `host_busy` in 1, `host_data_out` in 8: from `sdspihost`.

## Operation
States:
- **INIT_RST**: `host_rst`=1 for exactly one cycle, then → INIT_BUSY.
- **INIT_BUSY**: wait for `host_busy`=1 → INIT_IDLE.
- **INIT_IDLE**: wait for `host_busy`=0 → IDLE.
- **IDLE**: `ready`=1. Arbitration:
  - Only one `req` high: grant it.
  - Both high: grant the port that is not `last`, a 1-bit register reset to 1 so port 0 wins first.
  - Next state is GNT0 or GNT1, and `last` is updated on entry.
- **GNT0 / GNT1**: `gnt_i`=1, `ready`=1.
  - Host strobes and `host_block_addr` combinationally follow the owner's `r_block_i`, `r_multi_i`, `r_byte_i`, `addr_i`.
  - Owner's `req_i`=0 → RELEASE.
- **RELEASE**: `gnt`=0; all host strobes forced 0 and `host_block_addr`=0. When `host_busy`=0 → IDLE.
- **Watchdog** (see below) → INIT_RST with `timeout_err` set.

Rules:
- Outside GNT states, all host strobes are 0 and `host_block_addr`=0.
- The non-owner's strobes are ignored at all times.
- A requester that drops `req` before seeing `gnt`:
  - If `req` is low in IDLE, it is not granted.
  - If the grant was already registered, the next cycle goes GNT → RELEASE.
- Watchdog:
  - A TIMEOUT_W-bit counter increments each cycle `host_busy`=1 in INIT_IDLE, GNT0, GNT1 or RELEASE. It clears whenever `host_busy`=0 or in any other state.
  - When the counter equals all-ones, the next state is INIT_RST and `timeout_err`←1.
  - Grants drop in that same transition and the counter clears.
  - INIT_BUSY is not watchdogged.
- `busy_i` is 1 when not granted, so a requester FSM written against `sdspihost` stalls safely.

## Timing
- Reset values (first cycle after `rst`): state INIT_RST, so `host_rst`=1.
  - `gnt0`=`gnt1`=0, `ready`=0, `timeout_err`=0, `busy0`=`busy1`=1.
  - All other host strobes 0, `host_block_addr`=0, `last`=1, watchdog=0.
- `rst` asserted mid-grant: in the next cycle the arbiter is back in INIT_RST and the host is re-initialised. Requester state is not preserved.
- Grant latency: `req` sampled high in IDLE → `gnt` high on the next clock edge, a minimum of 1 cycle.
- Strobe passthrough: zero latency. Combinational from owner inputs while in GNT.
- Release: owner `req` low at edge N → RELEASE at N+1. When `host_busy`=0 at N+1 → IDLE at N+2, and a new grant at N+3.
- `ready` is 1 in IDLE, GNT0, GNT1 and RELEASE, and 0 in INIT states.

## Test plan
1. **Init.**
   - Stimulus: after `rst`, host model raises busy 3 cycles after `host_rst` and drops it 10 cycles later.
   - Required: `host_rst` high exactly 1 cycle; `ready` rises the cycle after busy falls; `busy0`=`busy1`=1 throughout.
2. **Single requester.**
   - Stimulus: `req0`=1, `addr0`=0x00000005, `r_block0` held.
   - Required: `gnt0` one cycle later; `host_block_addr`=5 and `host_r_block`=1 while granted; `gnt1`=0; `busy1`=1.
3. **Simultaneous requests.**
   - Stimulus: `req0`=`req1`=1 continuously, each owner dropping `req` after 20 cycles and re-raising it.
   - Required: grants alternate 0,1,0,1; never both high; ≥2 cycles of no grant between owners.
4. **Release while busy.**
   - Stimulus: owner drops `req` while `host_busy`=1 for 6 more cycles.
   - Required: state stays RELEASE with host strobes 0 for 6 cycles; next grant only after busy falls.
5. **Watchdog.**
   - Stimulus: TIMEOUT_W=4; host busy stuck high during GNT0.
   - Required: after 15 busy cycles `gnt0` falls, `timeout_err`=1, `host_rst` pulses, and init re-runs.
   - Required: `timeout_err` stays 1 after `ready` returns.
6. **Reset mid-grant.**
   - Stimulus: `rst` during GNT1.
   - Required: next cycle `gnt1`=0, `host_rst`=1, `timeout_err`=0, and the first grant after init goes to port 0 when both request.
